// File: rtl/jtyiear_pkg.sv
// Shared types for the Yie Ar graphics ROM fetcher.
// FSM encoding, slot ids and SDRAM address helper.
package jtyiear_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_LO,
    ST_HI
  } state_t;

  localparam logic SLOT_SCR = 1'b0;
  localparam logic SLOT_OBJ = 1'b1;

  function automatic logic [21:0] rom_addr(
    input logic [21:0] base,
    input logic [13:0] word
  );
    return base + {7'd0, word, 1'b0};
  endfunction

endpackage

// File: rtl/jtyiear_gfx_rom_if.sv
// Video-side ROM port: address/select in, data/ok out.
// master drives the request, slave answers from cache.
interface jtyiear_gfx_rom_if #(
  parameter int AW = 13
);
  logic [AW-1:0] addr;
  logic          cs;
  logic [31:0]   data;
  logic          ok;

  modport master (
    output addr,
    output cs,
    input  data,
    input  ok
  );

  modport slave (
    input  addr,
    input  cs,
    output data,
    output ok
  );
endinterface

// File: rtl/jtyiear_rom_slot.sv
// One-entry cache for a single ROM consumer.
// Reports hit as ok and raises pend on a miss.
module jtyiear_rom_slot #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  jtyiear_gfx_rom_if.slave bus,
  input  logic          we,
  input  logic [AW-1:0] wtag,
  input  logic [31:0]   wdata,
  output logic          pend
);

  logic [AW-1:0] tag_q, tag_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          hit;

  // Load a completed fill into the entry.
  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (we) begin
      tag_d   = wtag;
      data_d  = wdata;
      valid_d = 1'b1;
    end
  end

  // Cache entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign hit =
    valid_q && (tag_q == bus.addr) && bus.cs;

  assign bus.ok   = hit;
  assign bus.data = data_q;
  assign pend     = bus.cs && !hit;

endmodule

// File: rtl/jtyiear_gfx_rom.sv
// Scroll/object ROM fetcher over a shared SDRAM port.
// Round-robin arbiter and 32-bit two-halfword fill FSM.
module jtyiear_gfx_rom
  import jtyiear_pkg::*;
#(
  parameter logic [21:0] SCR_OFFSET = 22'h00_0000,
  parameter logic [21:0] OBJ_OFFSET = 22'h00_4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [13:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [15:0] sdram_din
);

  jtyiear_gfx_rom_if #(.AW(13)) scr_bus ();
  jtyiear_gfx_rom_if #(.AW(14)) obj_bus ();

  assign scr_bus.addr = scr_addr;
  assign scr_bus.cs   = 1'b1;
  assign scr_data     = scr_bus.data;
  assign scr_ok       = scr_bus.ok;

  assign obj_bus.addr = obj_addr;
  assign obj_bus.cs   = obj_cs;
  assign obj_data     = obj_bus.data;
  assign obj_ok       = obj_bus.ok;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [13:0] tag_q, tag_d;
  logic [15:0] lo_q, lo_d;
  logic        req_q, req_d;
  logic [21:0] addr_q, addr_d;

  logic        scr_pend, obj_pend;
  logic        scr_we, obj_we;
  logic [31:0] fill_data;

  assign fill_data = {sdram_din, lo_q};

  jtyiear_rom_slot #(.AW(13)) u_scr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (scr_bus.slave),
    .we    (scr_we),
    .wtag  (tag_q[12:0]),
    .wdata (fill_data),
    .pend  (scr_pend)
  );

  jtyiear_rom_slot #(.AW(14)) u_obj (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (obj_bus.slave),
    .we    (obj_we),
    .wtag  (tag_q),
    .wdata (fill_data),
    .pend  (obj_pend)
  );

  // Arbitrate, drive the SDRAM request, collect halfwords.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    tag_d   = tag_q;
    lo_d    = lo_q;
    req_d   = req_q;
    addr_d  = addr_q;
    scr_we  = 1'b0;
    obj_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (scr_pend || obj_pend) begin
          if (scr_pend &&
              (!obj_pend || last_q == SLOT_OBJ)) begin
            sel_d  = SLOT_SCR;
            tag_d  = {1'b0, scr_addr};
            addr_d = rom_addr(SCR_OFFSET,
                              {1'b0, scr_addr});
          end else begin
            sel_d  = SLOT_OBJ;
            tag_d  = obj_addr;
            addr_d = rom_addr(OBJ_OFFSET, obj_addr);
          end
          last_d  = sel_d;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (data_rdy) begin
          lo_d    = sdram_din;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (data_rdy) begin
          scr_we  = (sel_q == SLOT_SCR);
          obj_we  = (sel_q == SLOT_OBJ);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SLOT_SCR;
      last_q  <= SLOT_OBJ;
      tag_q   <= '0;
      lo_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
      lo_q    <= lo_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtyiear_gfx_rom.sv
// Scoreboard bench for jtyiear_gfx_rom.
// Randomised SDRAM timing against a word-level ROM model.
module tb_jtyiear_gfx_rom;

  localparam logic [21:0] SOFF = 22'h00_0000;
  localparam logic [21:0] OOFF = 22'h00_4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [15:0] sdram_din = 16'h0;
  logic        sdram_req;
  logic [21:0] sdram_addr;

  jtyiear_gfx_rom_if #(.AW(13)) scr_if ();
  jtyiear_gfx_rom_if #(.AW(14)) obj_if ();

  logic [31:0] w_sd, w_od;
  logic        w_so, w_oo, w_req;
  logic [21:0] w_addr;

  always #5 clk = ~clk;

  jtyiear_gfx_rom dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scr_addr   (scr_if.addr),
    .scr_data   (scr_if.data),
    .scr_ok     (scr_if.ok),
    .obj_cs     (obj_if.cs),
    .obj_addr   (obj_if.addr),
    .obj_data   (obj_if.data),
    .obj_ok     (obj_if.ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .sdram_din  (sdram_din)
  );

  jtyiear_gfx_rom #(.SCR_OFFSET(22'h3F_FFFE)) dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .scr_addr   (13'h0001),
    .scr_data   (w_sd),
    .scr_ok     (w_so),
    .obj_cs     (1'b0),
    .obj_addr   (14'h0000),
    .obj_data   (w_od),
    .obj_ok     (w_oo),
    .sdram_req  (w_req),
    .sdram_addr (w_addr),
    .sdram_ack  (1'b0),
    .data_rdy   (1'b0),
    .sdram_din  (16'h0000)
  );

  int checks = 0;
  int failures = 0;
  int scr_drops = 0;
  logic hold_scr = 1'b0;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t scr_q[$];
  exp_t obj_q[$];
  logic [15:0] mem [logic [21:0]];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [21:0] a);
    logic [31:0] t;
    if (mem.exists(a)) return mem[a];
    t = {10'd0, a} * 32'd40503 + 32'd23130;
    return t[15:0];
  endfunction

  function automatic logic [21:0] hbase(input logic [21:0] off,
                                        input logic [13:0] w);
    return off + 22'(w) * 22'd2;
  endfunction

  function automatic logic [31:0] word(input logic [21:0] off,
                                       input logic [13:0] w);
    logic [21:0] b;
    b = hbase(off, w);
    return {rd(b + 22'd1), rd(b)};
  endfunction

  task automatic set_scr(input logic [12:0] a);
    scr_if.addr = a;
    scr_q.push_back(exp_t'{addr: {1'b0, a},
                           data: word(SOFF, {1'b0, a})});
  endtask

  task automatic set_obj(input logic [13:0] a);
    obj_if.addr = a;
    obj_q.push_back(exp_t'{addr: a, data: word(OOFF, a)});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic serve(input int mode,
                       input logic [12:0] na,
                       output logic [21:0] a);
    int n;
    n = 0;
    a = '0;
    while (!sdram_req && n < 100) begin
      step();
      n++;
    end
    if (!sdram_req) begin
      chk("req_timeout", 64'(sdram_req), 64'd1);
      return;
    end
    a = sdram_addr;
    repeat ($urandom_range(0, 3)) begin
      data_rdy  = 1'($urandom_range(0, 1));
      sdram_din = 16'hDEAD;
      step();
    end
    data_rdy  = 1'b0;
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    if (mode == 1) set_scr(na);
    repeat ($urandom_range(0, 3)) begin
      sdram_ack = 1'($urandom_range(0, 1));
      step();
    end
    sdram_ack = 1'b0;
    sdram_din = rd(a);
    data_rdy  = 1'b1;
    step();
    data_rdy  = 1'b0;
    if (mode == 2) return;
    repeat ($urandom_range(0, 3)) step();
    sdram_din = rd(a + 22'd1);
    data_rdy  = 1'b1;
    step();
    data_rdy  = 1'b0;
    sdram_din = 16'h0;
  endtask

  // Monitor: pop the scoreboard when a slot presents new data.
  initial begin
    logic p_sok, p_ook;
    logic [12:0] p_sa;
    logic [13:0] p_oa;
    exp_t e;
    p_sok = 1'b0;
    p_ook = 1'b0;
    p_sa  = '0;
    p_oa  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_scr && !scr_if.ok) scr_drops++;
        if (scr_if.cs && scr_if.ok &&
            (!p_sok || scr_if.addr != p_sa)) begin
          if (scr_q.size() == 0) begin
            chk("scr_unexpected", 64'(scr_q.size()), 64'd1);
          end else begin
            e = scr_q.pop_front();
            chk("scr_sb_addr", 64'(scr_if.addr), 64'(e.addr));
            chk("scr_sb_data", 64'(scr_if.data), 64'(e.data));
          end
        end
        if (obj_if.ok &&
            (!p_ook || obj_if.addr != p_oa)) begin
          if (obj_q.size() == 0) begin
            chk("obj_unexpected", 64'(obj_q.size()), 64'd1);
          end else begin
            e = obj_q.pop_front();
            chk("obj_sb_addr", 64'(obj_if.addr), 64'(e.addr));
            chk("obj_sb_data", 64'(obj_if.data), 64'(e.data));
          end
        end
      end
      p_sok = scr_if.ok;
      p_ook = obj_if.ok;
      p_sa  = scr_if.addr;
      p_oa  = obj_if.addr;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by a randomised alternation run.
  initial begin
    logic [21:0] a;
    logic        sel, prev;
    logic [12:0] ns;
    logic [13:0] no;
    scr_if.cs   = 1'b1;
    obj_if.cs   = 1'b0;
    obj_if.addr = 14'h0;
    scr_if.addr = 13'h0;
    mem[22'h20] = 16'h1234;
    mem[22'h21] = 16'h5678;
    set_scr(13'h0010);
    #2;
    chk("rst_req", 64'(sdram_req), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_scr_ok", 64'(scr_if.ok), 64'd0);
    chk("rst_obj_ok", 64'(obj_if.ok), 64'd0);
    chk("rst_scr_data", 64'(scr_if.data), 64'd0);
    chk("rst_obj_data", 64'(obj_if.data), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rel_scr_ok", 64'(scr_if.ok), 64'd0);
    chk("rel_obj_ok", 64'(obj_if.ok), 64'd0);
    chk("rel_scr_data", 64'(scr_if.data), 64'd0);
    chk("rel_obj_data", 64'(obj_if.data), 64'd0);
    chk("wrap_req", 64'(w_req), 64'd1);
    chk("wrap_addr", 64'(w_addr), 64'd0);

    serve(0, 13'h0, a);
    chk("scr_fill_addr", 64'(a), 64'h20);
    chk("scr_fill_ok", 64'(scr_if.ok), 64'd1);
    chk("scr_fill_data", 64'(scr_if.data), 64'h5678_1234);

    hold_scr  = 1'b1;
    obj_if.cs = 1'b1;
    set_obj(14'h0003);
    serve(0, 13'h0, a);
    chk("obj_fill_addr", 64'(a), 64'h4006);
    chk("obj_fill_ok", 64'(obj_if.ok), 64'd1);
    step();
    hold_scr = 1'b0;
    chk("scr_hold", 64'(scr_drops), 64'd0);

    set_scr(13'h0040);
    serve(2, 13'h0, a);
    chk("abort_addr", 64'(a), 64'h80);
    rst_n = 1'b0;
    #1;
    chk("abort_req", 64'(sdram_req), 64'd0);
    chk("abort_scr_ok", 64'(scr_if.ok), 64'd0);
    chk("abort_obj_ok", 64'(obj_if.ok), 64'd0);
    set_obj(14'h0005);
    step();
    step();
    rst_n = 1'b1;
    serve(0, 13'h0, a);
    chk("post_abort_first", 64'(a), 64'h80);
    serve(0, 13'h0, a);
    chk("post_abort_obj", 64'(a), 64'h400A);

    scr_if.addr = 13'h0010;
    serve(1, 13'h0011, a);
    chk("move_first_addr", 64'(a), 64'h20);
    chk("move_ok_low", 64'(scr_if.ok), 64'd0);
    chk("move_idle_req", 64'(sdram_req), 64'd0);
    step();
    chk("move_ok_low2", 64'(scr_if.ok), 64'd0);
    chk("turnaround_req", 64'(sdram_req), 64'd1);
    serve(0, 13'h0, a);
    chk("move_second_addr", 64'(a), 64'h22);

    prev = 1'b0;
    do ns = 13'($urandom); while (ns == scr_if.addr);
    do no = 14'($urandom); while (no == obj_if.addr);
    set_scr(ns);
    set_obj(no);
    for (int i = 0; i < 12; i++) begin
      serve(0, 13'h0, a);
      sel = (a >= OOFF);
      chk("alternate", 64'(sel), 64'(!prev));
      chk("grant_addr", 64'(a),
          64'(sel ? hbase(OOFF, obj_if.addr)
                  : hbase(SOFF, {1'b0, scr_if.addr})));
      prev = sel;
      if (i < 10) begin
        if (sel) begin
          do no = 14'($urandom); while (no == obj_if.addr);
          set_obj(no);
        end else begin
          do ns = 13'($urandom); while (ns == scr_if.addr);
          set_scr(ns);
        end
      end
    end
    step();
    step();
    chk("scr_q_empty", 64'(scr_q.size()), 64'd0);
    chk("obj_q_empty", 64'(obj_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/jtyiear_gfx_rom.md
JTYIEAR_GFX_ROM -- requirements
Module: jtyiear_gfx_rom

Interface
REQ-001 Parameters: SCR_OFFSET, 22 bits, default 22'h00_0000, SDRAM halfword base of scroll ROM; OBJ_OFFSET, 22 bits, default 22'h00_4000, SDRAM halfword base of object ROM.
REQ-002 Ports, in order: clk, in, 1, 48 MHz clock, single clock domain.
REQ-003 rst_n, in, 1, asynchronous active-low reset.
REQ-004 scr_addr, in, 13, scroll 32-bit word address; always requesting, no cs.
REQ-005 scr_data, out, 32, scroll data; scr_ok, out, 1, scr_data valid for the current scr_addr.
REQ-006 obj_cs, in, 1, object request; obj_addr, in, 14, object 32-bit word address.
REQ-007 obj_data, out, 32, object data; obj_ok, out, 1, obj_data valid for the current obj_addr.
REQ-008 sdram_req, out, 1; sdram_addr, out, 22, halfword address; sdram_ack, in, 1; data_rdy, in, 1; sdram_din, in, 16.

Function
REQ-009 Each slot holds a one-entry cache: tag (slot address width), 32-bit data, valid bit.
REQ-010 Hit: scr hit = valid & tag==scr_addr; obj hit = valid & tag==obj_addr & obj_cs.
REQ-011 *_ok = hit, combinational from cache registers; *_data = cache data register at all times.
REQ-012 Miss: scroll always pending when not hit; object pending only when obj_cs=1 and not hit.
REQ-013 FSM states IDLE, REQ, LO, HI; one transaction in flight.
REQ-014 IDLE: if any slot pending, select slot, latch its address, go to REQ the next cycle.
REQ-015 Arbitration round-robin: with both pending, serve the slot not served last; after reset, scroll first.
REQ-016 sdram_addr = offset + {latched_addr,1'b0}, 22-bit wrap-around on overflow; stable from REQ until HI completes.
REQ-017 REQ: sdram_req=1 held until a cycle with sdram_ack=1; sdram_req drops the following cycle; go to LO.
REQ-018 LO: on data_rdy=1, sdram_din -> data[15:0]; go to HI.
REQ-019 HI: on data_rdy=1, sdram_din -> data[31:16]; write tag, data, valid=1 to the selected slot; return to IDLE.
REQ-020 Fill latency: *_ok rises the cycle after the HI data_rdy cycle if the address is unchanged.
REQ-021 Address change mid-fill: the fill completes and is stored with the latched tag; ok stays low; re-request issues from IDLE.
REQ-022 obj_cs drop mid-fill: fill completes and is cached; no abort.
REQ-023 data_rdy in IDLE or REQ is ignored; sdram_ack outside REQ is ignored.
REQ-024 Minimum turnaround: a new REQ starts two cycles after HI completes (IDLE takes one cycle).

Reset
REQ-025 rst_n=0 asynchronously: state IDLE, sdram_req=0, sdram_addr=0, both valid bits 0, tags 0, data 0, last-served = object (so scroll wins first).
REQ-026 While in reset and in the first cycle after release: scr_ok=0, obj_ok=0, scr_data=0, obj_data=0.
REQ-027 Reset mid-transaction abandons it; no partial data written to any cache.

Structure
REQ-028 FSM state encoding and the slot index constants (SLOT_SCR, SLOT_OBJ) are defined in the shared jtyiear_pkg package.
REQ-029 One sub-module, jtyiear_rom_slot, instantiated twice: holds tag/data/valid and computes hit/ok; the FSM and arbiter stay in the top.
REQ-030 No PROM, no clock enables; the block is ready for direct connection to the video block's scr_*/obj_* ports.

Verification
REQ-031 Reset release, scr_addr=13'h0010, obj_cs=0: sdram_req rises, sdram_addr=22'h00_0020; after ack and halfwords 16'h1234, 16'h5678, scr_data=32'h5678_1234 and scr_ok=1 next cycle.
REQ-032 scr_addr held and obj_cs=1, obj_addr=14'h0003: object fill at sdram_addr=22'h00_4006; scr_ok stays 1 throughout, obj_ok=1 after fill.
REQ-033 Both slots missing continuously (scr_addr, obj_addr changed every fill): grants alternate scr, obj, scr, obj; no slot served twice in a row.
REQ-034 scr_addr changed from 13'h0010 to 13'h0011 between ack and first data_rdy: scr_ok stays 0, second request issued at sdram_addr=22'h00_0022.
REQ-035 rst_n pulsed low between the two data_rdy pulses: sdram_req=0 immediately, both ok=0, first post-reset request is scroll.
REQ-036 SCR_OFFSET=22'h3F_FFFE, scr_addr=13'h0001: sdram_addr wraps to 22'h00_0000.
